// File: rtl/int_ctrl.sv
// Six-source interrupt controller: synchronizes device requests, latches them per-bit as
// edge or level, masks them into a registered CPU interrupt vector and exposes a 4-word window.
module int_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  dev_irq,
  input  logic        sel,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic [5:0]  hw_int,
  output logic        irq_valid,
  output logic [2:0]  irq_id
);

  logic [5:0] s1_q, s2_q, s3_q;
  logic [5:0] mask_q, mask_d;
  logic [5:0] mode_q, mode_d;
  logic [5:0] pend_q, pend_d;
  logic [5:0] edge_det, w1c, mode_rise;
  logic       wr;
  logic       unused_wd;

  assign unused_wd = ^wd[31:6];
  assign wr        = sel & we;
  assign edge_det  = s2_q & ~s3_q;
  assign w1c       = (wr && addr == 2'd2) ? wd[5:0] : 6'd0;
  // Switching a bit into edge mode starts it from a clean slate.
  assign mode_rise = (wr && addr == 2'd1) ? (wd[5:0] & ~mode_q) : 6'd0;

  always_comb begin
    mask_d = mask_q;
    mode_d = mode_q;
    if (wr && addr == 2'd0) mask_d = wd[5:0];
    if (wr && addr == 2'd1) mode_d = wd[5:0];
  end

  always_comb begin
    pend_d = pend_q;
    for (int i = 0; i < 6; i++) begin
      if (mode_rise[i]) begin
        pend_d[i] = 1'b0;
      end else if (!mode_q[i]) begin
        pend_d[i] = s2_q[i];
      end else begin
        // Set takes priority over a simultaneous W1C.
        pend_d[i] = edge_det[i] | (pend_q[i] & ~w1c[i]);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q   <= 6'd0;
      s2_q   <= 6'd0;
      s3_q   <= 6'd0;
      mask_q <= 6'd0;
      mode_q <= 6'd0;
      pend_q <= 6'd0;
      hw_int <= 6'd0;
    end else begin
      s1_q   <= dev_irq;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      mask_q <= mask_d;
      mode_q <= mode_d;
      pend_q <= pend_d;
      hw_int <= pend_q & mask_q;
    end
  end

  assign irq_valid = |hw_int;

  always_comb begin
    irq_id = 3'd0;
    for (int i = 5; i >= 0; i--) begin
      if (hw_int[i]) irq_id = 3'(i);
    end
  end

  always_comb begin
    rd = 32'd0;
    if (sel) begin
      case (addr)
        2'd0:    rd = {26'd0, mask_q};
        2'd1:    rd = {26'd0, mode_q};
        2'd2:    rd = {26'd0, pend_q};
        default: rd = {irq_valid, 28'd0, irq_id};
      endcase
    end
  end

endmodule

// File: tb/tb_int_ctrl.sv
// Directed self-checking bench for int_ctrl: edge/level paths, W1C, priority, masking,
// bus gating, set/clear collision and asynchronous reset behaviour.
module tb_int_ctrl;

  logic        clk;
  logic        reset;
  logic [5:0]  dev_irq;
  logic        sel;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] wd;
  logic [31:0] rd;
  logic [5:0]  hw_int;
  logic        irq_valid;
  logic [2:0]  irq_id;

  int n_checks = 0;
  int n_fail   = 0;

  int_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .dev_irq   (dev_irq),
    .sel       (sel),
    .we        (we),
    .addr      (addr),
    .wd        (wd),
    .rd        (rd),
    .hw_int    (hw_int),
    .irq_valid (irq_valid),
    .irq_id    (irq_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
    sel = 1'b1; we = 1'b1; addr = a; wd = d;
    tick();
    sel = 1'b0; we = 1'b0;
  endtask

  task automatic read_reg(input logic [1:0] a, output logic [31:0] d);
    sel = 1'b1; we = 1'b0; addr = a;
    #1;
    d = rd;
    sel = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    #3;
    n_checks++;
    if (hw_int !== 6'd0 || irq_valid !== 1'b0 || irq_id !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: hw_int=%h valid=%b id=%0d, required 0/0/0", hw_int, irq_valid, irq_id);
    end
    for (int a = 0; a < 4; a++) begin
      read_reg(2'(a), d);
      n_checks++;
      if (d !== 32'd0) begin
        n_fail++;
        $display("FAIL reset_reg%0d: got %h, required 00000000", a, d);
      end
    end
    tick();
    reset = 1'b1;
    tick();
    n_checks++;
    if (hw_int !== 6'd0) begin
      n_fail++;
      $display("FAIL reset_release: hw_int=%h, required 00", hw_int);
    end
  endtask

  task automatic test_edge();
    logic [31:0] d;
    write_reg(2'd0, 32'h3F);
    write_reg(2'd1, 32'h3F);
    tick();
    tick();
    dev_irq = 6'h08;
    tick();                       // edge N samples the pulse
    dev_irq = 6'h00;
    tick();                       // N+1
    read_reg(2'd2, d);
    n_checks++;
    if (d !== 32'h0) begin
      n_fail++;
      $display("FAIL edge_pend_n1: got %h, required 00000000", d);
    end
    tick();                       // N+2
    read_reg(2'd2, d);
    n_checks++;
    if (d !== 32'h08 || hw_int !== 6'h00) begin
      n_fail++;
      $display("FAIL edge_pend_n2: pend=%h hw_int=%h, required 08/00", d, hw_int);
    end
    tick();                       // N+3
    n_checks++;
    if (hw_int !== 6'h08 || irq_id !== 3'd3 || irq_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL edge_hw_n3: hw_int=%h id=%0d valid=%b, required 08/3/1", hw_int, irq_id, irq_valid);
    end
    repeat (3) tick();
    n_checks++;
    if (hw_int !== 6'h08) begin
      n_fail++;
      $display("FAIL edge_hold: hw_int=%h, required 08", hw_int);
    end
  endtask

  task automatic test_w1c();
    logic [31:0] d;
    write_reg(2'd2, 32'h08);
    read_reg(2'd2, d);
    n_checks++;
    if (d !== 32'h0 || hw_int !== 6'h08) begin
      n_fail++;
      $display("FAIL w1c_pend: pend=%h hw_int=%h, required 00/08", d, hw_int);
    end
    tick();
    read_reg(2'd3, d);
    n_checks++;
    if (hw_int !== 6'h00 || d !== 32'h0) begin
      n_fail++;
      $display("FAIL w1c_hw: hw_int=%h status=%h, required 00/00000000", hw_int, d);
    end
  endtask

  task automatic test_level();
    logic [31:0] d;
    write_reg(2'd1, 32'h00);
    tick();
    dev_irq = 6'h20;
    for (int k = 1; k <= 10; k++) begin
      if (k == 5) begin
        sel = 1'b1; we = 1'b1; addr = 2'd2; wd = 32'h20;
      end
      tick();                     // edge N+k-1
      sel = 1'b0; we = 1'b0;
      if (k == 3) begin
        n_checks++;
        if (hw_int !== 6'h00) begin
          n_fail++;
          $display("FAIL level_early: hw_int=%h, required 00", hw_int);
        end
      end
      if (k == 4) begin
        n_checks++;
        if (hw_int !== 6'h20 || irq_id !== 3'd5) begin
          n_fail++;
          $display("FAIL level_rise: hw_int=%h id=%0d, required 20/5", hw_int, irq_id);
        end
      end
      if (k == 6) begin
        read_reg(2'd2, d);
        n_checks++;
        if (d !== 32'h20 || hw_int !== 6'h20) begin
          n_fail++;
          $display("FAIL level_w1c: pend=%h hw_int=%h, required 20/20", d, hw_int);
        end
      end
    end
    dev_irq = 6'h00;
    for (int j = 1; j <= 4; j++) begin
      tick();                     // edge N+9+j
      if (j == 3) begin
        n_checks++;
        if (hw_int !== 6'h20) begin
          n_fail++;
          $display("FAIL level_tail: hw_int=%h, required 20", hw_int);
        end
      end
      if (j == 4) begin
        n_checks++;
        if (hw_int !== 6'h00) begin
          n_fail++;
          $display("FAIL level_fall: hw_int=%h, required 00", hw_int);
        end
      end
    end
  endtask

  task automatic test_priority_mask();
    logic [31:0] d;
    write_reg(2'd1, 32'h3F);
    dev_irq = 6'h12;
    tick();
    dev_irq = 6'h00;
    repeat (3) tick();
    n_checks++;
    if (hw_int !== 6'h12 || irq_id !== 3'd1 || irq_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL prio_both: hw_int=%h id=%0d valid=%b, required 12/1/1", hw_int, irq_id, irq_valid);
    end
    write_reg(2'd0, 32'h3D);
    n_checks++;
    if (hw_int !== 6'h12) begin
      n_fail++;
      $display("FAIL mask_write_edge: hw_int=%h, required 12", hw_int);
    end
    tick();
    read_reg(2'd2, d);
    n_checks++;
    if (hw_int !== 6'h10 || irq_id !== 3'd4 || d !== 32'h12) begin
      n_fail++;
      $display("FAIL mask_apply: hw_int=%h id=%0d pend=%h, required 10/4/12", hw_int, irq_id, d);
    end
  endtask

  task automatic test_bus_gating();
    logic [31:0] d;
    sel = 1'b0; we = 1'b1; addr = 2'd0; wd = 32'h0;
    tick();
    we = 1'b0;
    #1;
    n_checks++;
    if (rd !== 32'h0) begin
      n_fail++;
      $display("FAIL unsel_read: rd=%h, required 00000000", rd);
    end
    read_reg(2'd0, d);
    n_checks++;
    if (d !== 32'h3D) begin
      n_fail++;
      $display("FAIL unsel_write: mask=%h, required 0000003d", d);
    end
    write_reg(2'd3, 32'hFFFF_FFFF);
    read_reg(2'd1, d);
    n_checks++;
    if (d !== 32'h3F) begin
      n_fail++;
      $display("FAIL status_write_mode: mode=%h, required 0000003f", d);
    end
    read_reg(2'd3, d);
    n_checks++;
    if (d !== 32'h8000_0004) begin
      n_fail++;
      $display("FAIL status_read: got %h, required 80000004", d);
    end
  endtask

  task automatic test_collision_reset();
    logic [31:0] d;
    write_reg(2'd2, 32'h3F);
    write_reg(2'd0, 32'h3F);
    dev_irq = 6'h04;
    tick();                       // N
    dev_irq = 6'h00;
    tick();                       // N+1
    sel = 1'b1; we = 1'b1; addr = 2'd2; wd = 32'h04;
    tick();                       // N+2: edge set meets W1C
    sel = 1'b0; we = 1'b0;
    read_reg(2'd2, d);
    n_checks++;
    if (d !== 32'h04) begin
      n_fail++;
      $display("FAIL collision_pend: got %h, required 00000004", d);
    end
    tick();
    n_checks++;
    if (hw_int !== 6'h04 || irq_id !== 3'd2) begin
      n_fail++;
      $display("FAIL collision_hw: hw_int=%h id=%0d, required 04/2", hw_int, irq_id);
    end
    dev_irq = 6'h3F;
    reset = 1'b0;
    #1;
    n_checks++;
    if (hw_int !== 6'h00 || irq_valid !== 1'b0 || irq_id !== 3'd0) begin
      n_fail++;
      $display("FAIL async_reset: hw_int=%h valid=%b id=%0d, required 00/0/0", hw_int, irq_valid, irq_id);
    end
    read_reg(2'd2, d);
    n_checks++;
    if (d !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_pend: got %h, required 00000000", d);
    end
    tick();
    reset = 1'b1;
    write_reg(2'd1, 32'h3F);      // R1
    read_reg(2'd2, d);
    n_checks++;
    if (d !== 32'h0) begin
      n_fail++;
      $display("FAIL redetect_r1: pend=%h, required 00000000", d);
    end
    tick();                       // R2
    read_reg(2'd2, d);
    n_checks++;
    if (d !== 32'h0) begin
      n_fail++;
      $display("FAIL redetect_r2: pend=%h, required 00000000", d);
    end
    tick();                       // R3
    read_reg(2'd2, d);
    n_checks++;
    if (d !== 32'h3F || hw_int !== 6'h00) begin
      n_fail++;
      $display("FAIL redetect_r3: pend=%h hw_int=%h, required 3f/00", d, hw_int);
    end
    write_reg(2'd2, 32'h3F);
    repeat (3) tick();
    read_reg(2'd2, d);
    n_checks++;
    if (d !== 32'h0) begin
      n_fail++;
      $display("FAIL redetect_once: pend=%h, required 00000000", d);
    end
  endtask

  initial begin
    reset = 1'b0; dev_irq = 6'h0; sel = 1'b0; we = 1'b0; addr = 2'd0; wd = 32'h0;
    test_reset();
    test_edge();
    test_w1c();
    test_level();
    test_priority_mask();
    test_bus_gating();
    test_collision_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
